// File: rtl/seq_divider16_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master side issues operations; the slave side (the divider) reports results.
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             op_start;
  logic             op_clear;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             op_done;
  logic             div_by_zero;

  modport master (
    output op_start, op_clear, dividend, divisor,
    input  quotient, remainder, busy, op_done, div_by_zero
  );

  modport slave (
    input  op_start, op_clear, dividend, divisor,
    output quotient, remainder, busy, op_done, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Results appear in DONE and are held there until an explicit clear.
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  seq_divider16_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r_work, q_work, d_work;
  logic [CNT_W-1:0] iter_cnt;
  logic [WIDTH-1:0] quot_res, rem_res;
  logic             dz_res;

  logic [WIDTH-1:0] r_shift, diff, step_r, step_q;
  logic             carry_lo, no_borrow, last_iter;

  assign last_iter = (iter_cnt == CNT_W'(WIDTH - 1));

  // Trial subtract R - D at WIDTH+1 bits as R + ~D + 1. The shifted-out MSB of R
  // is the top bit of the trial operand; with ~D's top bit being 1, the final
  // carry-out is that MSB OR'd with the carry out of the low WIDTH bits.
  always_comb begin
    r_shift               = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
    {carry_lo, diff}      = {1'b0, r_shift} + {1'b0, ~d_work} + (WIDTH+1)'(1);
    no_borrow             = r_work[WIDTH-1] | carry_lo;
    step_r                = no_borrow ? diff : r_shift;
    step_q                = {q_work[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.op_clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.op_start) state_nxt = (bus.divisor == '0) ? DONE : EXEC;
        EXEC:    if (last_iter)    state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work   <= '0;
      q_work   <= '0;
      d_work   <= '0;
      iter_cnt <= '0;
      quot_res <= '0;
      rem_res  <= '0;
      dz_res   <= 1'b0;
    end else if (bus.op_clear) begin
      r_work   <= '0;
      q_work   <= '0;
      d_work   <= '0;
      iter_cnt <= '0;
      quot_res <= '0;
      rem_res  <= '0;
      dz_res   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.op_start) begin
          r_work   <= '0;
          q_work   <= bus.dividend;
          d_work   <= bus.divisor;
          iter_cnt <= '0;
          if (bus.divisor == '0) begin
            quot_res <= '1;
            rem_res  <= bus.dividend;
            dz_res   <= 1'b1;
          end
        end
        EXEC: begin
          r_work   <= step_r;
          q_work   <= step_q;
          iter_cnt <= iter_cnt + 1'b1;
          if (last_iter) begin
            quot_res <= step_q;
            rem_res  <= step_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == EXEC);
  assign bus.op_done     = (state == DONE);
  assign bus.quotient    = quot_res;
  assign bus.remainder   = rem_res;
  assign bus.div_by_zero = dz_res;

endmodule
